// File: rtl/hilo_divide_unit.sv
// HI/LO register owner and handshake front end for the iterative divider.
// Accepts DIV/DIVU from EX, issues a one-cycle request, and commits quotient/remainder to LO/HI.
module hilo_divide_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_div_valid,
  input  logic                  ex_div_signed,
  input  logic [DATA_WIDTH-1:0] ex_dividend,
  input  logic [DATA_WIDTH-1:0] ex_divisor,
  output logic                  ex_div_ready,
  input  logic                  ex_mthi_valid,
  input  logic                  ex_mtlo_valid,
  input  logic [DATA_WIDTH-1:0] ex_mt_data,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] hi_value,
  output logic [DATA_WIDTH-1:0] lo_value,
  output logic                  hilo_busy,
  output logic                  div_done,
  output logic                  divider_request_valid,
  output logic                  divider_is_signed,
  output logic [DATA_WIDTH-1:0] divider_input1,
  output logic [DATA_WIDTH-1:0] divider_input2,
  input  logic                  divider_result_valid,
  input  logic [DATA_WIDTH-1:0] divider_result,
  input  logic [DATA_WIDTH-1:0] divider_remain
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  op_signed_q, op_signed_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  done_q, done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_signed_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_signed_q <= op_signed_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_signed_d = op_signed_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An MT and a divide in the same cycle both proceed; the divide overwrites later.
        if (!flush) begin
          if (ex_mthi_valid) hi_d = ex_mt_data;
          if (ex_mtlo_valid) lo_d = ex_mt_data;
          if (ex_div_valid) begin
            op_a_d      = ex_dividend;
            op_b_d      = ex_divisor;
            op_signed_d = ex_div_signed;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        // The request has already gone out, so a flush must still wait out the divider.
        state_d = flush ? StDrain : StWait;
      end
      StWait: begin
        if (divider_result_valid) begin
          hi_d    = divider_remain;
          lo_d    = divider_result;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (divider_result_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ex_div_ready          = (state_q == StIdle);
  assign hilo_busy             = (state_q != StIdle);
  assign divider_request_valid = (state_q == StIssue);
  assign divider_is_signed     = op_signed_q;
  assign divider_input1        = op_a_q;
  assign divider_input2        = op_b_q;
  assign hi_value              = hi_q;
  assign lo_value              = lo_q;
  assign div_done              = done_q;

endmodule
